// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: byte width, default
// bit period and the arbiter FSM state encoding.
// Optional feature macro: UART_ARB_GAP_EN (adds the inter-byte GAP state).
package uart_pkg;

    localparam int BYTE_W               = 8;
    localparam int CLKS_PER_BIT_DEFAULT = 217;

`ifdef UART_ARB_GAP_EN
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2,
        GAP       = 2'd3
    } arb_state_t;
`else
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2
    } arb_state_t;
`endif

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority encoder. Searches the request
// vector starting at index ptr and wrapping modulo NUM_REQ; returns the first
// requester found and a flag saying whether any request was present.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     ptr,
    output logic [IDW-1:0]     winner,
    output logic               found
);

    localparam int SW = IDW + 1;

    logic [IDW-1:0]     cand_idx [NUM_REQ];
    logic [NUM_REQ-1:0] cand_hit;

    // Candidate gi is the requester gi places after the pointer (mod NUM_REQ).
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            logic [SW-1:0] sum;
            assign sum          = {1'b0, ptr} + SW'(gi);
            assign cand_idx[gi] = (sum >= SW'(NUM_REQ)) ? IDW'(sum - SW'(NUM_REQ))
                                                        : sum[IDW-1:0];
            assign cand_hit[gi] = req[cand_idx[gi]];
        end
    endgenerate

    // Lowest rotated offset wins: scan from the far end so the nearest hit is kept.
    always_comb begin
        winner = '0;
        found  = |cand_hit;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (cand_hit[i]) begin
                winner = cand_idx[i];
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter between NUM_REQ byte sources
// using round-robin arbitration. A grant latches the winner's byte, pulses
// o_TX_DV together with the winner's ready bit, then waits for i_TX_Done.
// Optional feature macro: UART_ARB_GAP_EN inserts CLKS_PER_BIT*GAP_BITS
// cycles from i_TX_Done to the next start strobe (GAP state).
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int GAP_BITS     = 1
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic [NUM_REQ-1:0]           i_req_valid,
    input  logic [BYTE_W*NUM_REQ-1:0]    i_req_byte,
    output logic [NUM_REQ-1:0]           o_req_ready,
    output logic                         o_TX_DV,
    output logic [BYTE_W-1:0]            o_TX_Byte,
    input  logic                         i_TX_Active,
    input  logic                         i_TX_Done,
    output logic [$clog2(NUM_REQ)-1:0]   o_grant_id,
    output logic                         o_busy
);

    localparam int IDW = $clog2(NUM_REQ);

    arb_state_t        state_reg;
    arb_state_t        state_next;
    logic [IDW-1:0]    ptr_reg;
    logic [IDW-1:0]    grant_reg;
    logic [BYTE_W-1:0] byte_reg;

    logic [IDW-1:0]    pick_id;
    logic              pick_found;
    logic              grant_fire;
    logic [BYTE_W-1:0] req_bytes [NUM_REQ];

    // Unpack the flat byte bus into one byte per requester.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_bytes
            assign req_bytes[gi] = i_req_byte[gi*BYTE_W +: BYTE_W];
        end
    endgenerate

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_rr_pick (
        .req    (i_req_valid),
        .ptr    (ptr_reg),
        .winner (pick_id),
        .found  (pick_found)
    );

    // A stray transmission (i_TX_Active in IDLE) blocks granting until it ends.
    assign grant_fire = (state_reg == IDLE) && pick_found && !i_TX_Active;

`ifdef UART_ARB_GAP_EN
    // The IDLE and ISSUE cycles after GAP account for two cycles of the
    // Done-to-DV spacing, so GAP itself lasts GAP_CYCLES-2 cycles.
    localparam int GAP_CYCLES = CLKS_PER_BIT * GAP_BITS;
    localparam int GAP_LOAD   = (GAP_CYCLES > 3) ? GAP_CYCLES - 3 : 0;
    localparam int GCW        = $clog2(GAP_LOAD + 2);

    logic [GCW-1:0] gap_cnt_reg;
    logic           gap_done;

    assign gap_done = (gap_cnt_reg == '0);

    // Gap counter: loaded on Done, counts down to zero while in GAP.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            gap_cnt_reg <= '0;
        end else if ((state_reg == WAIT_DONE) && i_TX_Done) begin
            gap_cnt_reg <= GCW'(GAP_LOAD);
        end else if ((state_reg == GAP) && !gap_done) begin
            gap_cnt_reg <= gap_cnt_reg - 1'b1;
        end
    end
`endif

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next-state logic; i_TX_Done is only looked at in WAIT_DONE.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (grant_fire) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                state_next = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (i_TX_Done) begin
`ifdef UART_ARB_GAP_EN
                    state_next = GAP;
`else
                    state_next = IDLE;
`endif
                end
            end
`ifdef UART_ARB_GAP_EN
            GAP: begin
                if (gap_done) begin
                    state_next = IDLE;
                end
            end
`endif
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Grant bookkeeping: winner id, its byte, and the next search start.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ptr_reg   <= '0;
            grant_reg <= '0;
            byte_reg  <= '0;
        end else if (grant_fire) begin
            grant_reg <= pick_id;
            byte_reg  <= req_bytes[pick_id];
            ptr_reg   <= (pick_id == IDW'(NUM_REQ - 1)) ? '0 : pick_id + 1'b1;
        end
    end

    // Ready is one-hot by construction: only the registered winner can match.
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign o_req_ready[gi] = (state_reg == ISSUE) && (grant_reg == IDW'(gi));
        end
    endgenerate

    assign o_TX_DV    = (state_reg == ISSUE);
    assign o_busy     = (state_reg != IDLE);
    assign o_TX_Byte  = byte_reg;
    assign o_grant_id = grant_reg;

endmodule
